// File: rtl/id_stage.sv
// id_stage: MIPS32 instruction-decode stage with a 32x32 register file,
// branch/jump resolution in ID and the ID/EX pipeline register.
// Optional macro ID_FORWARD_EN: when defined, operands take EX/MEM forwards and
// only load-use stalls. When undefined, forward inputs are ignored and ID
// stalls until a pending result reaches the register file.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic [31:0] ins,
  input  logic        ex_fwd_we,
  input  logic [4:0]  ex_fwd_waddr,
  input  logic [31:0] ex_fwd_wdata,
  input  logic        mem_fwd_we,
  input  logic [4:0]  mem_fwd_waddr,
  input  logic [31:0] mem_fwd_wdata,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] jpc,
  output logic        if_pc_jump,
  output logic        if_bubble,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [3:0]  ex_alu_op,
  output logic [4:0]  ex_waddr,
  output logic        ex_we,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr
);

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Instruction fields
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm16;
  logic [25:0] w_idx;
  logic [31:0] w_sext, w_zext;

  assign w_op    = ins[31:26];
  assign w_rs    = ins[25:21];
  assign w_rt    = ins[20:16];
  assign w_rd    = ins[15:11];
  assign w_shamt = ins[10:6];
  assign w_funct = ins[5:0];
  assign w_imm16 = ins[15:0];
  assign w_idx   = ins[25:0];
  assign w_sext  = {{16{w_imm16[15]}}, w_imm16};
  assign w_zext  = {16'h0000, w_imm16};

  // Decode results
  logic        w_valid, w_rs_used, w_rt_used, w_we, w_mem_rd, w_mem_wr;
  logic        w_is_beq, w_is_bne, w_is_j, w_is_jal, w_is_jr;
  logic [4:0]  w_waddr;
  logic [31:0] w_imm;
  alu_op_e     w_alu;

  // Register file and ID/EX register
  logic [31:0] r_rf [32];
  logic [31:0] r_ex_pc, r_ex_a, r_ex_b, r_ex_imm;
  alu_op_e     r_ex_alu_op;
  logic [4:0]  r_ex_waddr;
  logic        r_ex_we, r_ex_mem_rd, r_ex_mem_wr;

  logic [31:0] w_rf_rs, w_rf_rt, w_rs_val, w_rt_val;
  logic [31:0] w_a, w_b, w_br_tgt, w_j_tgt, w_tgt;
  logic        w_hazard, w_taken;

  // Instruction decode: unrecognised encodings leave w_valid low and issue a NOP
  always_comb begin
    w_valid   = 1'b0;
    w_rs_used = 1'b0;
    w_rt_used = 1'b0;
    w_we      = 1'b0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_is_beq  = 1'b0;
    w_is_bne  = 1'b0;
    w_is_j    = 1'b0;
    w_is_jal  = 1'b0;
    w_is_jr   = 1'b0;
    w_waddr   = '0;
    w_imm     = '0;
    w_alu     = ALU_NOP;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT: begin
            w_valid   = 1'b1;
            w_rs_used = 1'b1;
            w_rt_used = 1'b1;
            w_we      = 1'b1;
            w_waddr   = w_rd;
            case (w_funct)
              FN_ADDU: w_alu = ALU_ADD;
              FN_SUBU: w_alu = ALU_SUB;
              FN_AND:  w_alu = ALU_AND;
              FN_OR:   w_alu = ALU_OR;
              FN_XOR:  w_alu = ALU_XOR;
              default: w_alu = ALU_SLT;
            endcase
          end
          FN_SLL, FN_SRL: begin
            w_valid   = 1'b1;
            w_rt_used = 1'b1;
            w_we      = 1'b1;
            w_waddr   = w_rd;
            w_imm     = {27'd0, w_shamt};
            w_alu     = (w_funct == FN_SLL) ? ALU_SLL : ALU_SRL;
          end
          FN_JR: begin
            w_valid   = 1'b1;
            w_rs_used = 1'b1;
            w_is_jr   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        w_valid   = 1'b1;
        w_rs_used = 1'b1;
        w_we      = 1'b1;
        w_waddr   = w_rt;
        w_imm     = (w_op == OP_ADDIU) ? w_sext : w_zext;
        case (w_op)
          OP_ADDIU: w_alu = ALU_ADD;
          OP_ANDI:  w_alu = ALU_AND;
          OP_ORI:   w_alu = ALU_OR;
          default:  w_alu = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        w_valid = 1'b1;
        w_we    = 1'b1;
        w_waddr = w_rt;
        w_imm   = {w_imm16, 16'h0000};
        w_alu   = ALU_LUI;
      end
      OP_LW: begin
        w_valid   = 1'b1;
        w_rs_used = 1'b1;
        w_we      = 1'b1;
        w_mem_rd  = 1'b1;
        w_waddr   = w_rt;
        w_imm     = w_sext;
        w_alu     = ALU_ADD;
      end
      OP_SW: begin
        w_valid   = 1'b1;
        w_rs_used = 1'b1;
        w_rt_used = 1'b1;
        w_mem_wr  = 1'b1;
        w_imm     = w_sext;
        w_alu     = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        w_valid   = 1'b1;
        w_rs_used = 1'b1;
        w_rt_used = 1'b1;
        w_imm     = w_sext;
        w_is_beq  = (w_op == OP_BEQ);
        w_is_bne  = (w_op == OP_BNE);
      end
      OP_J: begin
        w_valid = 1'b1;
        w_is_j  = 1'b1;
      end
      OP_JAL: begin
        w_valid  = 1'b1;
        w_is_j   = 1'b1;
        w_is_jal = 1'b1;
        w_we     = 1'b1;
        w_waddr  = 5'd31;
      end
      default: ;
    endcase
  end

  // Register-file read ports: $0 reads zero, same-cycle WB writes pass straight through
  assign w_rf_rs = (w_rs == 5'd0) ? '0 :
                   (wb_we && (wb_waddr == w_rs)) ? wb_wdata : r_rf[w_rs];
  assign w_rf_rt = (w_rt == 5'd0) ? '0 :
                   (wb_we && (wb_waddr == w_rt)) ? wb_wdata : r_rf[w_rt];

`ifdef ID_FORWARD_EN
  // EX result wins over MEM, MEM over the register file
  assign w_rs_val = (ex_fwd_we && (ex_fwd_waddr == w_rs) && (w_rs != 5'd0)) ? ex_fwd_wdata :
                    (mem_fwd_we && (mem_fwd_waddr == w_rs) && (w_rs != 5'd0)) ? mem_fwd_wdata :
                    w_rf_rs;
  assign w_rt_val = (ex_fwd_we && (ex_fwd_waddr == w_rt) && (w_rt != 5'd0)) ? ex_fwd_wdata :
                    (mem_fwd_we && (mem_fwd_waddr == w_rt) && (w_rt != 5'd0)) ? mem_fwd_wdata :
                    w_rf_rt;
  // Only a load sitting in ID/EX cannot be forwarded in time
  assign w_hazard = r_ex_mem_rd && (r_ex_waddr != 5'd0) &&
                    ((w_rs_used && (w_rs == r_ex_waddr)) ||
                     (w_rt_used && (w_rt == r_ex_waddr)));
`else
  logic w_rs_pend, w_rt_pend;
  logic w_unused;

  assign w_unused = ^{ex_fwd_wdata, mem_fwd_wdata};
  assign w_rs_val = w_rf_rs;
  assign w_rt_val = w_rf_rt;
  // A source is pending while any later stage still owes it a write
  assign w_rs_pend = (w_rs != 5'd0) &&
                     ((ex_fwd_we && (ex_fwd_waddr == w_rs)) ||
                      (mem_fwd_we && (mem_fwd_waddr == w_rs)) ||
                      (r_ex_we && (r_ex_waddr == w_rs)));
  assign w_rt_pend = (w_rt != 5'd0) &&
                     ((ex_fwd_we && (ex_fwd_waddr == w_rt)) ||
                      (mem_fwd_we && (mem_fwd_waddr == w_rt)) ||
                      (r_ex_we && (r_ex_waddr == w_rt)));
  assign w_hazard = (w_rs_used && w_rs_pend) || (w_rt_used && w_rt_pend);
`endif

  // Operand shaping: unused rs reads as 0; when rt is unused, B carries the immediate
  // so EX sees a uniform A-op-B for I-type ALU ops. JAL passes its link address in A.
  always_comb begin
    w_a = w_rs_used ? w_rs_val : '0;
    if (w_is_jal) w_a = npc + 32'd4;
    w_b = w_rt_used ? w_rt_val : w_imm;
  end

  assign w_br_tgt = npc + {w_sext[29:0], 2'b00};
  assign w_j_tgt  = {npc[31:28], w_idx, 2'b00};

  // Branch and jump resolution in ID
  always_comb begin
    w_taken = 1'b0;
    w_tgt   = '0;
    if ((w_is_beq && (w_rs_val == w_rt_val)) || (w_is_bne && (w_rs_val != w_rt_val))) begin
      w_taken = 1'b1;
      w_tgt   = w_br_tgt;
    end else if (w_is_j) begin
      w_taken = 1'b1;
      w_tgt   = w_j_tgt;
    end else if (w_is_jr) begin
      w_taken = 1'b1;
      w_tgt   = w_rs_val;
    end
  end

  assign if_bubble  = ~rst & w_hazard;
  assign if_pc_jump = ~rst & ~w_hazard & w_taken;
  assign jpc        = if_pc_jump ? w_tgt : '0;

  // Register file write port; $0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (wb_we && (wb_waddr != 5'd0)) begin
      r_rf[wb_waddr] <= wb_wdata;
    end
  end

  // ID/EX register: stalls and undecoded words clock in an all-zero NOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_pc     <= '0;
      r_ex_a      <= '0;
      r_ex_b      <= '0;
      r_ex_imm    <= '0;
      r_ex_alu_op <= ALU_NOP;
      r_ex_waddr  <= '0;
      r_ex_we     <= 1'b0;
      r_ex_mem_rd <= 1'b0;
      r_ex_mem_wr <= 1'b0;
    end else if (w_hazard || !w_valid) begin
      r_ex_pc     <= '0;
      r_ex_a      <= '0;
      r_ex_b      <= '0;
      r_ex_imm    <= '0;
      r_ex_alu_op <= ALU_NOP;
      r_ex_waddr  <= '0;
      r_ex_we     <= 1'b0;
      r_ex_mem_rd <= 1'b0;
      r_ex_mem_wr <= 1'b0;
    end else begin
      r_ex_pc     <= npc - 32'd4;
      r_ex_a      <= w_a;
      r_ex_b      <= w_b;
      r_ex_imm    <= w_imm;
      r_ex_alu_op <= w_alu;
      r_ex_waddr  <= w_waddr;
      r_ex_we     <= w_we;
      r_ex_mem_rd <= w_mem_rd;
      r_ex_mem_wr <= w_mem_wr;
    end
  end

  assign ex_pc     = r_ex_pc;
  assign ex_a      = r_ex_a;
  assign ex_b      = r_ex_b;
  assign ex_imm    = r_ex_imm;
  assign ex_alu_op = r_ex_alu_op;
  assign ex_waddr  = r_ex_waddr;
  assign ex_we     = r_ex_we;
  assign ex_mem_rd = r_ex_mem_rd;
  assign ex_mem_wr = r_ex_mem_wr;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector table for id_stage plus hand-written stall,
// branch-wait and reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc, ins;
  logic        ex_fwd_we, mem_fwd_we, wb_we;
  logic [4:0]  ex_fwd_waddr, mem_fwd_waddr, wb_waddr;
  logic [31:0] ex_fwd_wdata, mem_fwd_wdata, wb_wdata;
  logic [31:0] jpc, ex_pc, ex_a, ex_b, ex_imm;
  logic        if_pc_jump, if_bubble, ex_we, ex_mem_rd, ex_mem_wr;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_waddr;

  int n_pass = 0;
  int n_tot  = 0;

  localparam logic [31:0] IDLE = 32'hFC00_0000;

  id_stage dut (
    .clk(clk), .rst(rst), .npc(npc), .ins(ins),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_waddr(ex_fwd_waddr), .ex_fwd_wdata(ex_fwd_wdata),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr), .mem_fwd_wdata(mem_fwd_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .jpc(jpc), .if_pc_jump(if_pc_jump), .if_bubble(if_bubble),
    .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_waddr(ex_waddr), .ex_we(ex_we),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] npc, ins;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        jump;
    logic [31:0] jpc, pc, a, b, imm;
    logic [3:0]  op;
    logic [4:0]  waddr;
    logic        we, rd, wr;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] rt(input logic [4:0] s, input logic [4:0] t,
                                     input logic [4:0] d, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] s,
                                     input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] jt(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    // npc, ins, wb_we, wb_waddr, wb_wdata, jump, jpc, pc, a, b, imm, op, waddr, we, rd, wr
    vq.push_back(vec_t'{32'h1004, rt(1,1,2,0,6'h21), 1'b1, 5'd1, 32'd5, 1'b0, 32'h0,
                        32'h1000, 32'd5, 32'd5, 32'h0, 4'd1, 5'd2, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, rt(6,7,3,0,6'h23), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h10, 32'hFFFF_FFF0, 32'h0, 4'd2, 5'd3, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, rt(7,6,4,0,6'h2A), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'hFFFF_FFF0, 32'h10, 32'h0, 4'd6, 5'd4, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, rt(6,8,5,4,6'h00), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h0, 32'h0F0F_00FF, 32'h4, 4'd7, 5'd5, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, rt(0,8,18,31,6'h02), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h0, 32'h0F0F_00FF, 32'h1F, 4'd8, 5'd18, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, it(6'h09,6,10,16'hFFFD), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h10, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 4'd1, 5'd10, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, it(6'h0D,7,11,16'h8001), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'hFFFF_FFF0, 32'h8001, 32'h8001, 4'd4, 5'd11, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, it(6'h0F,0,12,16'h1234), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h0, 32'h1234_0000, 32'h1234_0000, 4'd9, 5'd12, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, it(6'h23,6,13,16'h0008), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h10, 32'h8, 32'h8, 4'd1, 5'd13, 1'b1, 1'b1, 1'b0});
    vq.push_back(vec_t'{32'h1004, it(6'h2B,6,8,16'hFFFC), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h10, 32'h0F0F_00FF, 32'hFFFF_FFFC, 4'd1, 5'd0, 1'b0, 1'b0, 1'b1});
    vq.push_back(vec_t'{32'h1004, it(6'h04,6,6,16'h0002), 1'b0, 5'd0, 32'd0, 1'b1, 32'h100C,
                        32'h1000, 32'h10, 32'h10, 32'h2, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, it(6'h05,6,6,16'h0002), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h10, 32'h10, 32'h2, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h8000_0008, it(6'h04,0,0,16'h0004), 1'b0, 5'd0, 32'd0, 1'b1, 32'h8000_0018,
                        32'h8000_0004, 32'h0, 32'h0, 32'h4, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h8000_0004, jt(6'h03,26'h40), 1'b0, 5'd0, 32'd0, 1'b1, 32'h8000_0100,
                        32'h8000_0000, 32'h8000_0008, 32'h0, 32'h0, 4'd0, 5'd31, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h9000_0000, jt(6'h02,26'h3FF_FFFF), 1'b0, 5'd0, 32'd0, 1'b1, 32'h9FFF_FFFC,
                        32'h8FFF_FFFC, 32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, rt(9,0,0,0,6'h08), 1'b0, 5'd0, 32'd0, 1'b1, 32'h8000_0000,
                        32'h1000, 32'h8000_0000, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, 32'hFCE7_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, rt(6,7,3,0,6'h3F), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, it(6'h0C,0,19,16'hFFFF), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h0, 32'h0000_FFFF, 32'h0000_FFFF, 4'd3, 5'd19, 1'b1, 1'b0, 1'b0});
    vq.push_back(vec_t'{32'h1004, rt(8,7,20,0,6'h26), 1'b0, 5'd0, 32'd0, 1'b0, 32'h0,
                        32'h1000, 32'h0F0F_00FF, 32'hFFFF_FFF0, 32'h0, 4'd5, 5'd20, 1'b1, 1'b0, 1'b0});

    // Reset state, with a taken-branch word present to show the redirect is held off
    rst = 1'b1; npc = 32'h100; ins = it(6'h04,0,0,16'h0004);
    ex_fwd_we = 1'b0; ex_fwd_waddr = '0; ex_fwd_wdata = '0;
    mem_fwd_we = 1'b0; mem_fwd_waddr = '0; mem_fwd_wdata = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    #2;
    chk("rst.jump", if_pc_jump, 1'b0);
    chk("rst.jpc", jpc, 32'h0);
    chk("rst.bubble", if_bubble, 1'b0);
    step();
    chk("rst.we", ex_we, 1'b0);
    chk("rst.op", ex_alu_op, 4'd0);
    chk("rst.pc", ex_pc, 32'h0);
    step();
    rst = 1'b0; ins = IDLE;

    // Preload registers through the WB port
    wb_we = 1'b1;
    wb_waddr = 5'd6; wb_wdata = 32'h10;         step();
    wb_waddr = 5'd7; wb_wdata = 32'hFFFF_FFF0;  step();
    wb_waddr = 5'd8; wb_wdata = 32'h0F0F_00FF;  step();
    wb_waddr = 5'd9; wb_wdata = 32'h8000_0000;  step();
    wb_we = 1'b0;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      npc = v.npc; ins = v.ins;
      wb_we = v.wb_we; wb_waddr = v.wb_waddr; wb_wdata = v.wb_wdata;
      #1;
      chk($sformatf("v%0d.jump", i), if_pc_jump, v.jump);
      chk($sformatf("v%0d.jpc", i), jpc, v.jpc);
      chk($sformatf("v%0d.bubble", i), if_bubble, 1'b0);
      step();
      wb_we = 1'b0;
      chk($sformatf("v%0d.pc", i), ex_pc, v.pc);
      chk($sformatf("v%0d.a", i), ex_a, v.a);
      chk($sformatf("v%0d.b", i), ex_b, v.b);
      chk($sformatf("v%0d.imm", i), ex_imm, v.imm);
      chk($sformatf("v%0d.op", i), ex_alu_op, v.op);
      chk($sformatf("v%0d.waddr", i), ex_waddr, v.waddr);
      chk($sformatf("v%0d.we", i), ex_we, v.we);
      chk($sformatf("v%0d.mrd", i), ex_mem_rd, v.rd);
      chk($sformatf("v%0d.mwr", i), ex_mem_wr, v.wr);
      ins = IDLE;
      step();
    end

    // Load-use: LW $3 then ADDU $4,$3,$3
    npc = 32'h3004; ins = it(6'h23,0,3,16'h0000);
    #1 chk("lu.bubble0", if_bubble, 1'b0);
    step();
    chk("lu.mrd", ex_mem_rd, 1'b1);
    npc = 32'h3008; ins = rt(3,3,4,0,6'h21);
    #1;
    chk("lu.bubble1", if_bubble, 1'b1);
    chk("lu.jump1", if_pc_jump, 1'b0);
    step();
    chk("lu.nop_we", ex_we, 1'b0);
    chk("lu.nop_mrd", ex_mem_rd, 1'b0);
    chk("lu.nop_waddr", ex_waddr, 5'd0);
    mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd3; mem_fwd_wdata = 32'h11;
`ifdef ID_FORWARD_EN
    #1 chk("lu.bubble2", if_bubble, 1'b0);
    step();
    mem_fwd_we = 1'b0;
`else
    #1 chk("lu.bubble2", if_bubble, 1'b1);
    step();
    chk("lu.nop2_we", ex_we, 1'b0);
    mem_fwd_we = 1'b0;
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h11;
    #1 chk("lu.bubble3", if_bubble, 1'b0);
    step();
    wb_we = 1'b0;
`endif
    chk("lu.a", ex_a, 32'h11);
    chk("lu.b", ex_b, 32'h11);
    chk("lu.op", ex_alu_op, 4'd1);
    chk("lu.waddr", ex_waddr, 5'd4);
    ins = IDLE;
    step();

    // ADDIU $5,$0,7 then BNE $5,$0,+1: branch waits for $5
    npc = 32'h2000; ins = it(6'h09,0,5,16'h0007);
    step();
    npc = 32'h2004; ins = it(6'h05,5,0,16'h0001);
    ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd5; ex_fwd_wdata = 32'd7;
`ifdef ID_FORWARD_EN
    #1;
    chk("bw.bubble1", if_bubble, 1'b0);
    chk("bw.jump1", if_pc_jump, 1'b1);
    chk("bw.jpc1", jpc, 32'h2008);
    step();
    ex_fwd_we = 1'b0;
`else
    #1;
    chk("bw.bubble1", if_bubble, 1'b1);
    chk("bw.jump1", if_pc_jump, 1'b0);
    step();
    ex_fwd_we = 1'b0;
    mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd5; mem_fwd_wdata = 32'd7;
    #1;
    chk("bw.bubble2", if_bubble, 1'b1);
    chk("bw.jump2", if_pc_jump, 1'b0);
    step();
    mem_fwd_we = 1'b0;
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'd7;
    #1;
    chk("bw.bubble3", if_bubble, 1'b0);
    chk("bw.jump3", if_pc_jump, 1'b1);
    chk("bw.jpc3", jpc, 32'h2008);
    step();
    wb_we = 1'b0;
`endif
    ins = IDLE;
    step();

    // Reset pulsed mid-stall and mid-branch
    npc = 32'h5004; ins = it(6'h23,0,15,16'h0000);
    step();
    ins = rt(15,15,16,0,6'h21);
    #1 chk("rs.bubble_pre", if_bubble, 1'b1);
    #1 rst = 1'b1; ins = it(6'h04,0,0,16'h0004);
    #1;
    chk("rs.bubble", if_bubble, 1'b0);
    chk("rs.jump", if_pc_jump, 1'b0);
    chk("rs.jpc", jpc, 32'h0);
    chk("rs.mrd", ex_mem_rd, 1'b0);
    chk("rs.we", ex_we, 1'b0);
    chk("rs.waddr", ex_waddr, 5'd0);
    step();
    chk("rs.we_hold", ex_we, 1'b0);
    rst = 1'b0; npc = 32'h4004; ins = rt(1,6,17,0,6'h21);
    #1;
    chk("rs.post_bubble", if_bubble, 1'b0);
    chk("rs.post_jump", if_pc_jump, 1'b0);
    step();
    chk("rs.post_a", ex_a, 32'h0);
    chk("rs.post_b", ex_b, 32'h0);
    chk("rs.post_op", ex_alu_op, 4'd1);
    chk("rs.post_waddr", ex_waddr, 5'd17);
    chk("rs.post_we", ex_we, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
